// File: rtl/spm_stream_ctrl.sv
// spm_stream_ctrl
//   Upstream sequencer for spm_top. Accepts a signed operand pair on a valid/ready
//   input stream, presents it to spm_top on spm_mc/spm_mp, and raises spm_start.
//   The operands are stable for one cycle before spm_start rises. When spm_done
//   fires, the controller captures the product and offers it on a valid/ready
//   result stream. A watchdog ends the operation with out_err=1 and out_prod=0
//   if spm_done never arrives within TIMEOUT start-high cycles.
//
// Ports
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready      operand stream handshake; in_ready is high only in IDLE
//   in_mc, in_mp           signed operands (WIDTH)
//   out_valid/out_ready    result stream handshake
//   out_prod, out_err      signed 2*WIDTH product; error flag for a timeout (prod=0)
//   spm_mc, spm_mp         operands to spm_top, held from one acceptance to the next
//   spm_start              start to spm_top, high exactly while in RUN
//   spm_prod, spm_done     result from spm_top; done is ignored outside RUN
//   busy                   high whenever the FSM is not IDLE
//
// Optional feature
//   SPM_CTRL_ZERO_BYPASS_EN: when defined, a pair with a zero operand goes directly
//   from IDLE to DONE with out_prod=0, and spm_start is never raised for that pair.
module spm_stream_ctrl #(
  parameter int WIDTH    = 32,
  parameter int TIMEOUT  = 80,
  parameter int IDLE_GAP = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     in_mc,
  input  logic signed [WIDTH-1:0]     in_mp,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [2*WIDTH-1:0]   out_prod,
  output logic                        out_err,
  output logic signed [WIDTH-1:0]     spm_mc,
  output logic signed [WIDTH-1:0]     spm_mp,
  output logic                        spm_start,
  input  logic signed [2*WIDTH-1:0]   spm_prod,
  input  logic                        spm_done,
  output logic                        busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_GAP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept;
  logic             zero_pair;
  logic             run_done;
  logic             run_timeout;

  // Watchdog counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_comb begin
    accept      = in_valid && (state == S_IDLE);
`ifdef SPM_CTRL_ZERO_BYPASS_EN
    zero_pair   = (in_mc == '0) || (in_mp == '0);
`else
    zero_pair   = 1'b0;
`endif
    // done has priority over a timeout that expires in the same cycle
    run_done    = (state == S_RUN) && spm_done;
    run_timeout = (state == S_RUN) && !spm_done && (cnt == CNT_W'(TIMEOUT - 1));
    state_next  = state;
    unique case (state)
      S_IDLE: if (accept) state_next = zero_pair ? S_DONE : S_LOAD;
      S_LOAD: state_next = S_RUN;
      S_RUN:  if (run_done || run_timeout) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_GAP;
      S_GAP:  if (gap_cnt == GAP_W'(IDLE_GAP - 1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Registered outputs, watchdog and gap counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spm_mc    <= '0;
      spm_mp    <= '0;
      spm_start <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_prod  <= '0;
      cnt       <= '0;
      gap_cnt   <= '0;
    end else begin
      // Start follows the next state so it is high for exactly the RUN cycles.
      spm_start <= (state_next == S_RUN);

      if (accept) begin
        spm_mc <= in_mc;
        spm_mp <= in_mp;
      end

      if (state == S_LOAD)     cnt <= '0;
      else if (state == S_RUN) cnt <= sat_inc(cnt);

      if (state != S_GAP)      gap_cnt <= '0;
      else                     gap_cnt <= gap_cnt + 1'b1;

      if (run_done) begin
        out_prod  <= spm_prod;
        out_err   <= 1'b0;
        out_valid <= 1'b1;
      end else if (run_timeout) begin
        out_prod  <= '0;
        out_err   <= 1'b1;
        out_valid <= 1'b1;
      end else if (accept && zero_pair) begin
        out_prod  <= '0;
        out_err   <= 1'b0;
        out_valid <= 1'b1;
      end else if (state == S_DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spm_stream_ctrl.sv
module tb_spm_stream_ctrl;

  localparam int WIDTH   = 32;
  localparam int SPM_LAT = 10;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   in_mc = '0;
  logic signed [WIDTH-1:0]   in_mp = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic signed [2*WIDTH-1:0] out_prod;
  logic                      out_err;
  logic signed [WIDTH-1:0]   spm_mc;
  logic signed [WIDTH-1:0]   spm_mp;
  logic                      spm_start;
  logic signed [2*WIDTH-1:0] spm_prod = '0;
  logic                      spm_done = 1'b0;
  logic                      busy;

  spm_stream_ctrl #(.WIDTH(WIDTH), .TIMEOUT(80), .IDLE_GAP(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mc(in_mc), .in_mp(in_mp),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod), .out_err(out_err),
    .spm_mc(spm_mc), .spm_mp(spm_mp), .spm_start(spm_start),
    .spm_prod(spm_prod), .spm_done(spm_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic signed [2*WIDTH-1:0] exp_prod[$];
  logic                      exp_err[$];
  int hs_cnt = 0;

  // Partner multiplier: raises done SPM_LAT cycles into a start-high window.
  bit done_en = 1'b1;
  int run_cnt = 0;
  always @(posedge clk) begin
    if (!spm_start) begin
      run_cnt  <= 0;
      spm_done <= 1'b0;
    end else begin
      run_cnt <= run_cnt + 1;
      if (done_en && run_cnt == SPM_LAT - 1) begin
        spm_done <= 1'b1;
        spm_prod <= spm_mc * spm_mp;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: start-window statistics, operand stability, result scoreboard.
  int hi_len = 0, lo_len = 0, last_run = 0, runs = 0, min_lo = 1000, stab_bad = 0;
  logic signed [WIDTH-1:0] cap_mc = '0, cap_mp = '0;
  always @(negedge clk) begin
    if (spm_start) begin
      if (hi_len == 0 && runs > 0 && lo_len < min_lo) min_lo = lo_len;
      hi_len++;
      if (spm_mc !== cap_mc || spm_mp !== cap_mp) stab_bad++;
    end else begin
      if (hi_len > 0) begin
        last_run = hi_len;
        runs++;
        lo_len = 0;
      end
      hi_len = 0;
      lo_len++;
      cap_mc = spm_mc;
      cap_mp = spm_mp;
    end
    if (!rst && out_valid && out_ready) begin
      hs_cnt++;
      if (exp_prod.size() == 0) begin
        chk("unexpected_result", 64'(out_prod), 64'hDEAD);
      end else begin
        chk("result_prod", 64'(out_prod), 64'(exp_prod.pop_front()));
        chk("result_err", 64'(out_err), 64'(exp_err.pop_front()));
      end
    end
  end

  task automatic send(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b,
                      input logic signed [2*WIDTH-1:0] p, input logic e, input bit push);
    int n = 0;
    while (!in_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_wait_timeout", 64'(in_ready), 64'd1);
    in_mc = a;
    in_mp = b;
    in_valid = 1'b1;
    if (push) begin
      exp_prod.push_back(p);
      exp_err.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_prod.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_wait", 64'(exp_prod.size()), 64'd0);
  endtask

  int runs0, hs0, bp_bad;
  logic signed [2*WIDTH-1:0] held;

  initial begin
    // Reset state
    #2;
    chk("rst_spm_start", 64'(spm_start), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_out_prod", 64'(out_prod), 64'd0);
    chk("rst_spm_mc", 64'(spm_mc), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Basic multiply
    send(3, 4, 12, 1'b0, 1'b1);
    wait_empty();
    chk("basic_run_len", 64'(last_run), 64'(SPM_LAT + 1));

    // Signed pairs back to back
    send(-15, 10, -150, 1'b0, 1'b1);
    send(200, -50, -10000, 1'b0, 1'b1);
    send(-159, -129, 20511, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0, 1'b1);
    wait_empty();

    // Backpressure
    out_ready = 1'b0;
    hs0 = hs_cnt;
    send(9, 11, 99, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    held = out_prod;
    bp_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid || out_prod !== held || in_ready || spm_start) bp_bad++;
      @(posedge clk); #1;
    end
    chk("bp_hold_violations", 64'(bp_bad), 64'd0);
    chk("bp_held_prod", 64'(held), 64'd99);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_single_transfer", 64'(hs_cnt - hs0), 64'd1);
    chk("bp_valid_dropped", 64'(out_valid), 64'd0);

    // Timeout
    done_en = 1'b0;
    send(5, 5, 0, 1'b1, 1'b1);
    wait_empty();
    chk("timeout_run_len", 64'(last_run), 64'd80);
    done_en = 1'b1;
    send(7, -3, -21, 1'b0, 1'b1);
    wait_empty();

    // Asynchronous reset in the middle of RUN
    send(1000, 1000, 0, 1'b0, 1'b0);
    begin
      int n = 0;
      while (!spm_start && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
    end
    done_en = 1'b0;
    repeat (30) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_spm_start", 64'(spm_start), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    done_en = 1'b1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    send(6, 6, 36, 1'b0, 1'b1);
    wait_empty();

    // Zero operand
    runs0 = runs;
    send(0, -7, 0, 1'b0, 1'b1);
`ifdef SPM_CTRL_ZERO_BYPASS_EN
    chk("zero_valid_next_cycle", 64'(out_valid), 64'd1);
    wait_empty();
    repeat (3) @(posedge clk);
    #1;
    chk("zero_no_start", 64'(runs - runs0), 64'd0);
`else
    wait_empty();
    repeat (3) @(posedge clk);
    #1;
    chk("zero_full_path", 64'(runs - runs0), 64'd1);
`endif

    chk("operand_stability", 64'(stab_bad), 64'd0);
    chk("min_start_low_gap_ok", 64'(min_lo >= 2), 64'd1);
    chk("queue_empty", 64'(exp_prod.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
